// File: rtl/mem_boot_loader.sv
// rtl/mem_boot_loader.sv - host byte-stream boot loader sharing the CPU memory port
// Loads length/data/checksum frames into memory, then releases the CPU from reset.
module mem_boot_loader (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       reload,
  input  logic       cpu_memwrite,
  input  logic [7:0] cpu_adr,
  input  logic [7:0] cpu_writedata,
  output logic       memwrite,
  output logic [7:0] adr,
  output logic [7:0] writedata,
  output logic       cpu_reset,
  output logic       load_err
);

  typedef enum logic [2:0] {LEN, DATA, CSUM, RUN, ERR} state_t;

  state_t     state;
  logic [7:0] count;
  logic [7:0] ptr;
  logic [7:0] sum;
  logic [7:0] ld_adr;
  logic [7:0] ld_data;
  logic       pending;
  logic       xfer;
  logic [7:0] sum_next;

  assign xfer     = in_valid && in_ready;
  assign sum_next = sum + in_data;

  always_comb begin
    in_ready = 1'b0;
    case (state)
      LEN, CSUM: in_ready = 1'b1;
      DATA:      in_ready = !pending;
      default:   in_ready = 1'b0;
    endcase
  end

  // The CPU owns the memory port only in RUN; otherwise the loader's registers drive it.
  always_comb begin
    if (state == RUN) begin
      memwrite  = cpu_memwrite;
      adr       = cpu_adr;
      writedata = cpu_writedata;
    end else begin
      memwrite  = pending;
      adr       = ld_adr;
      writedata = ld_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= LEN;
      count     <= 8'h00;
      ptr       <= 8'h00;
      sum       <= 8'h00;
      ld_adr    <= 8'h00;
      ld_data   <= 8'h00;
      pending   <= 1'b0;
      cpu_reset <= 1'b1;
      load_err  <= 1'b0;
    end else begin
      case (state)
        LEN: begin
          if (xfer) begin
            count <= in_data;
            ptr   <= 8'h00;
            sum   <= 8'h00;
            state <= DATA;
          end
        end
        DATA: begin
          // count==0 encodes 256, so the final write is the one issued at count==1.
          if (pending) begin
            pending <= 1'b0;
            ptr     <= ptr + 8'h01;
            count   <= count - 8'h01;
            if (count == 8'h01) state <= CSUM;
          end else if (xfer) begin
            ld_adr  <= ptr;
            ld_data <= in_data;
            pending <= 1'b1;
            sum     <= sum_next;
          end
        end
        CSUM: begin
          if (xfer) begin
            if (sum_next == 8'h00) begin
              state     <= RUN;
              cpu_reset <= 1'b0;
            end else begin
              state    <= ERR;
              load_err <= 1'b1;
            end
          end
        end
        RUN, ERR: begin
          if (reload) begin
            state     <= LEN;
            cpu_reset <= 1'b1;
            load_err  <= 1'b0;
          end
        end
        default: state <= LEN;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_boot_loader.sv
// tb/tb_mem_boot_loader.sv - scoreboard bench for mem_boot_loader
// Stimulus pushes expected memory writes; a negedge monitor pops and compares them.
module tb_mem_boot_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       reload = 1'b0;
  logic       cpu_memwrite = 1'b0;
  logic [7:0] cpu_adr = 8'h00;
  logic [7:0] cpu_writedata = 8'h00;
  logic       memwrite;
  logic [7:0] adr;
  logic [7:0] writedata;
  logic       cpu_reset;
  logic       load_err;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  dbuf[0:255];

  mem_boot_loader dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .reload(reload), .cpu_memwrite(cpu_memwrite),
    .cpu_adr(cpu_adr), .cpu_writedata(cpu_writedata), .memwrite(memwrite),
    .adr(adr), .writedata(writedata), .cpu_reset(cpu_reset), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Loader-owned writes (cpu_reset high) must match the scoreboard in order.
  always @(negedge clk) begin
    logic [15:0] w;
    if (reset && memwrite && cpu_reset) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {16'h0, adr, writedata}, 32'hFFFFFFFF);
      end else begin
        w = exp_q.pop_front();
        check("write_adr", 32'(adr), 32'(w[15:8]));
        check("write_data", 32'(writedata), 32'(w[7:0]));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget = 0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    reload   = ($urandom_range(0, 3) == 0);
    while (!in_ready && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!in_ready) begin
      check("handshake_timeout", 32'(in_ready), 32'd1);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    reload   = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic do_load(input string tag, input logic [7:0] len_b, input int n,
                         input logic [7:0] csum, input bit gaps);
    int s = 0;
    bit good;
    for (int i = 0; i < n; i++) begin
      s += int'(dbuf[i]);
      exp_q.push_back({8'(i), dbuf[i]});
    end
    good = (((s + int'(csum)) % 256) == 0);
    send_byte(len_b, gaps);
    for (int i = 0; i < n; i++) send_byte(dbuf[i], gaps);
    send_byte(csum, gaps);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), good ? 32'd0 : 32'd1);
    check({tag, "_load_err"}, 32'(load_err), good ? 32'd0 : 32'd1);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_reload(input string tag);
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    check({tag, "_rl_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, "_rl_load_err"}, 32'(load_err), 32'd0);
    check({tag, "_rl_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_rl_memwrite"}, 32'(memwrite), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    int s;
    logic [7:0] cs;
    bit good;

    repeat (2) @(posedge clk);
    #1;
    check("rst_memwrite", 32'(memwrite), 32'd0);
    check("rst_adr", 32'(adr), 32'd0);
    check("rst_writedata", 32'(writedata), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_load_err", 32'(load_err), 32'd0);
    reset = 1'b1;
    #1;
    check("rst_rel_in_ready", 32'(in_ready), 32'd1);

    dbuf[0] = 8'h11; dbuf[1] = 8'h22; dbuf[2] = 8'h33;
    do_load("good", 8'h03, 3, 8'h9A, 1'b0);

    cpu_memwrite = 1'b1; cpu_adr = 8'h40; cpu_writedata = 8'h5A;
    #1;
    check("pt_memwrite", 32'(memwrite), 32'd1);
    check("pt_adr", 32'(adr), 32'h40);
    check("pt_writedata", 32'(writedata), 32'h5A);
    do_reload("pt");
    cpu_memwrite = 1'b0;

    dbuf[0] = 8'h55;
    do_load("bad", 8'h01, 1, 8'h00, 1'b0);
    do_reload("bad");

    for (int i = 0; i < 256; i++) dbuf[i] = 8'(i);
    do_load("full", 8'h00, 256, 8'h80, 1'b0);
    do_reload("full");

    exp_q.push_back({8'h00, 8'hA1});
    send_byte(8'h03, 1'b0);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hB2, 1'b0);
    reset = 1'b0;
    #1;
    check("midrst_memwrite", 32'(memwrite), 32'd0);
    check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("midrst_adr", 32'(adr), 32'd0);
    check("midrst_writedata", 32'(writedata), 32'd0);
    check("midrst_first_write_seen", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    dbuf[0] = 8'h77;
    do_load("after_rst", 8'h01, 1, 8'h89, 1'b0);
    do_reload("after_rst");

    for (int t = 0; t < 16; t++) begin
      n = $urandom_range(1, 12);
      s = 0;
      for (int i = 0; i < n; i++) begin
        dbuf[i] = 8'($urandom);
        s += int'(dbuf[i]);
      end
      good = ($urandom_range(0, 2) != 0);
      cs = 8'(256 - (s % 256));
      if (!good) cs = cs + 8'($urandom_range(1, 255));
      do_load("rand", 8'(n), n, cs, 1'b1);
      if (good) begin
        for (int k = 0; k < 3; k++) begin
          cpu_memwrite  = 1'($urandom);
          cpu_adr       = 8'($urandom);
          cpu_writedata = 8'($urandom);
          #1;
          check("rand_pt_memwrite", 32'(memwrite), 32'(cpu_memwrite));
          check("rand_pt_adr", 32'(adr), 32'(cpu_adr));
          check("rand_pt_writedata", 32'(writedata), 32'(cpu_writedata));
          @(posedge clk); #1;
        end
        cpu_memwrite = 1'b1;
      end
      do_reload("rand");
      cpu_memwrite = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
